// File: rtl/instruction_fetch.sv
// Instruction fetch stage: writable program memory, program counter and a
// registered valid/ready output toward decode, with jump redirects and end-of-program detection.
module instruction_fetch #(
  parameter int ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  // Handshake: a word moves to decode on any rising edge where
  // instr_valid && instr_ready; while valid && !ready the output register holds.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  prog_last;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic issue;
  logic redirect_take;
  logic restart;

  assign redirect_take = redirect_valid && (state != IDLE);
  assign issue         = (state == RUN) && (!instr_valid || instr_ready) && !redirect_valid;
  // A redirect in DONE takes priority over a concurrent start.
  assign restart       = start && ((state == IDLE) || ((state == DONE) && !redirect_valid));

  assign busy      = (state == RUN);
  assign done      = (state == DONE) && !instr_valid;
  assign dbg_state = state;

  // Program memory is intentionally left out of reset so a program survives it.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      prog_last   <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      if ((state == IDLE) && load_en) begin
        prog_last <= load_addr;
      end

      if (redirect_take) begin
        instr_valid <= 1'b0;
        pc          <= redirect_pc;
        state       <= (redirect_pc <= prog_last) ? RUN : DONE;
      end else if (restart) begin
        state <= RUN;
        pc    <= '0;
        if (instr_ready) begin
          instr_valid <= 1'b0;
        end
      end else if (issue) begin
        instr_out   <= mem[pc];
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + ADDR_WIDTH'(1);
        if (pc == prog_last) begin
          state <= DONE;
        end
      end else if (instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Stage directly upstream of instruction decode. Holds a small writable instruction memory, a program counter, and an output instruction register.
- Presents one 8-bit instruction per cycle to decode over a valid/ready handshake.
- Supports program loading while idle, downstream stalls, PC redirects (jumps), and end-of-program detection.

Parameters:
ADDR_WIDTH, 4, PC and memory address width; memory depth = 2**ADDR_WIDTH
INSTR_WIDTH, 8, instruction width; decode consumes fields [7:6] reg1, [5:4] reg2, [3:2] wreg, [1:0] type

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
load_en  input  1  write load_data to memory at load_addr (honoured only in IDLE)
load_addr  input  ADDR_WIDTH  load address
load_data  input  INSTR_WIDTH  load data
start  input  1  begin or restart execution at address 0 (honoured in IDLE and DONE)
redirect_valid  input  1  jump request
redirect_pc  input  ADDR_WIDTH  jump target
instr_ready  input  1  decode accepts instr_out this cycle
instr_out  output  INSTR_WIDTH  registered instruction to decode
instr_pc  output  ADDR_WIDTH  address of instr_out
instr_valid  output  1  instr_out holds a live instruction
busy  output  1  state == RUN
done  output  1  state == DONE and instr_valid == 0

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE; pc=0; prog_last=0; instr_out=0; instr_pc=0; instr_valid=0; busy=0; done=0.
  - Memory contents are not reset.
- States are IDLE, RUN, DONE.
- IDLE:
  - load_en writes mem[load_addr] <= load_data and sets prog_last <= load_addr. The last address written defines the program end.
  - start: state<=RUN, pc<=0. If load_en and start are both high, the write happens and start is also taken.
  - redirect_valid is ignored.
- Issue condition: issue = (state==RUN) && (!instr_valid || instr_ready) && !redirect_valid.
  - On issue: instr_out<=mem[pc], instr_pc<=pc, instr_valid<=1, pc<=pc+1 (modulo 2**ADDR_WIDTH).
  - If pc==prog_last at issue: state<=DONE.
- Handshake:
  - Transfer occurs when instr_valid && instr_ready.
  - If valid && !ready, instr_out, instr_pc and instr_valid hold stable and pc does not advance.
  - If ready without issue, instr_valid<=0.
- Redirect (RUN or DONE):
  - Flushes the output register: instr_valid<=0. A concurrently accepted instruction still counts as consumed.
  - pc<=redirect_pc. No issue that cycle.
  - If redirect_pc<=prog_last: state<=RUN. Otherwise state<=DONE, and nothing further is issued.
- Redirect in IDLE is ignored. A redirect wins over start if both are asserted in DONE.
- DONE:
  - Last instruction stays valid until accepted. done rises the cycle after it is accepted.
  - start: state<=RUN, pc<=0.
  - load_en is ignored.
- Latency:
  - start sampled at edge k: busy=1 after k, first instr_valid with mem[0] after edge k+1.
  - Steady state with instr_ready held high: one instruction per cycle.
  - After a redirect at edge j: bubble after j, target instruction valid after j+1.
- load_en in RUN or DONE is ignored; memory and prog_last are unchanged.

Test Plan:
- Load mem[0..3]={8'h1B,8'h6C,8'hE4,8'h02}, start, instr_ready=1 -> instr_valid high on 4 consecutive cycles with instr_pc 0,1,2,3 and those data; done=1 the cycle after pc 3 is accepted; busy=0.
- Same program, instr_ready=0 for 3 cycles after the first valid -> instr_out=8'h1B and instr_pc=0 held stable; pc not advanced; sequence resumes 8'h6C when ready returns.
- Program of 6 instructions, redirect_valid with redirect_pc=1 in the cycle instr_pc=3 is accepted -> one bubble (instr_valid=0), then instr_pc=1, 2, ...; no instruction from pc 4 appears before the jump target.
- redirect_pc=9 with prog_last=5 -> instr_valid stays 0, state DONE, done=1; start then restarts from instr_pc=0.
- load_en pulses during RUN targeting addr 2 -> memory unchanged (original mem[2] fetched); prog_last unchanged.
- Assert rst asynchronously mid-stream (instr_valid=1, between edges) -> all outputs 0 immediately; state IDLE; after deassert, start re-executes the retained program from address 0.
